// File: rtl/btn_toggle_pulse.sv
// ---------------------------------------------------------------------------
// btn_toggle_pulse
//
// Purpose:
//   Input conditioning for a pushbutton that drives a synchronous T flip-flop.
//   The raw level is passed through a two-flop synchroniser and then debounced
//   by a four-state FSM. Each accepted press produces exactly one single-cycle
//   T pulse. Releases and long holds never produce a pulse.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset with priority over all logic
//   btn          in   raw asynchronous pushbutton level, 1 = pressed
//   T            out  registered single-cycle toggle pulse
//   stable       out  registered debounced button level
//   press_count  out  pulses emitted so far, modulo 256
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive identical synchronised samples needed to
//                    accept a level change (2 .. 2**CNT_W - 1)
//   CNT_W            width of the debounce counter
// ---------------------------------------------------------------------------
module btn_toggle_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic       T,
  output logic       stable,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // debounced level low
    ST_DB_HIGH = 2'd1,  // qualifying a press
    ST_HIGH    = 2'd2,  // debounced level high
    ST_DB_LOW  = 2'd3   // qualifying a release
  } state_t;

  // The counter value on the sample that completes a qualification. The
  // sample that enters a DB_* state is already counted as 1, so the
  // DEBOUNCE_CYCLES-th consistent sample is seen while cnt holds this value.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  // Synchroniser
  logic r_s1;
  logic r_s2;

  // FSM and output registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_t;
  logic             r_stable;
  logic [7:0]       r_press_count;

  // Next-state values
  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_t_next;
  logic             w_stable_next;
  logic [7:0]       w_press_count_next;

  // Two-flop synchroniser; only r_s2 is seen by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_t           <= 1'b0;
      r_stable      <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_t           <= w_t_next;
      r_stable      <= w_stable_next;
      r_press_count <= w_press_count_next;
    end
  end

  // Next-state and output decode. T defaults low so that it can only be high
  // for the single cycle following the DB_HIGH -> HIGH transition.
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_t_next           = 1'b0;
    w_stable_next      = r_stable;
    w_press_count_next = r_press_count;

    case (r_state)
      ST_IDLE: begin
        if (r_s2) begin
          w_state_next = ST_DB_HIGH;
          w_cnt_next   = LP_CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end

      ST_DB_HIGH: begin
        if (!r_s2) begin
          // Bounce: drop back without touching the outputs.
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_next       = ST_HIGH;
          w_stable_next      = 1'b1;
          w_t_next           = 1'b1;
          w_press_count_next = r_press_count + 8'd1;  // wraps naturally
        end else begin
          w_cnt_next = r_cnt + LP_CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (!r_s2) begin
          w_state_next = ST_DB_LOW;
          w_cnt_next   = LP_CNT_ONE;
        end
      end

      ST_DB_LOW: begin
        if (r_s2) begin
          // Glitch during release: level stays high and no pulse is issued,
          // since the HIGH state has no path back to the pulsing edge.
          w_state_next = ST_HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_next  = ST_IDLE;
          w_stable_next = 1'b0;
        end else begin
          w_cnt_next = r_cnt + LP_CNT_ONE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign T           = r_t;
  assign stable      = r_stable;
  assign press_count = r_press_count;

endmodule

// File: doc/btn_toggle_pulse.md
Name: btn_toggle_pulse

Overview:
Upstream conditioning stage for the synchronous T flip-flop.
- Takes a raw, bouncy, asynchronous pushbutton level.
- Synchronises and debounces it.
- Emits exactly one single-cycle T pulse per debounced press. Downstream flop toggles once per physical press.
- Also exposes the debounced level and a wrapping press counter for observation.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples needed to accept a level change; legal range 2..(2^CNT_W - 1)
CNT_W, 3, debounce counter width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn  input  1  raw asynchronous pushbutton level, 1 = pressed
T  output  1  registered single-cycle toggle pulse, drives the T flip-flop T input
stable  output  1  registered debounced button level
press_count  output  8  number of pulses emitted, modulo 256

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high, sampled on rising clk, and has priority over all other logic.
- Reset values: s1=0, s2=0, state=IDLE, cnt=0, T=0, stable=0, press_count=0.
- Synchroniser: btn -> s1 -> s2, two flops. Only s2 feeds the FSM.
- States: IDLE (stable low), DB_HIGH (qualifying press), HIGH (stable high), DB_LOW (qualifying release).
- IDLE:
  - s2=1 -> DB_HIGH, cnt=1.
  - else stay, cnt=0.
- DB_HIGH:
  - s2=0 -> IDLE, cnt=0 (bounce reject, no pulse).
  - s2=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH; stable<=1, T<=1, press_count<=press_count+1.
  - else cnt<=cnt+1.
- HIGH:
  - s2=0 -> DB_LOW, cnt=1.
  - else stay.
- DB_LOW:
  - s2=1 -> HIGH, cnt=0 (bounce reject, stable stays 1, no pulse).
  - s2=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, stable<=0.
  - else cnt<=cnt+1.
- T rules:
  - T is 0 on every edge except the DB_HIGH->HIGH edge, so it is high exactly one cycle.
  - Release never produces a pulse.
  - Holding the button never produces additional pulses.
- Latency: btn rising and held, sampled first at edge E. T and stable go high after edge E+DEBOUNCE_CYCLES+1 (E+5 for default). stable falls after edge E'+DEBOUNCE_CYCLES+1 on release.
- press_count: 8-bit, increments only with T, wraps 255 -> 0.
- Reset mid-operation:
  - Any in-progress qualification is discarded.
  - If btn is still high when reset deasserts, a fresh press is qualified and a pulse issued after the normal latency.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES synchronised samples causes no change on T or stable.

Test Plan:
1. Reset held 3 cycles with btn=0, then released -> T=0, stable=0, press_count=0 throughout.
2. Clean press, btn 0->1 held 20 cycles, DEBOUNCE_CYCLES=4 -> T=1 for exactly one cycle, 5 edges after first sampling; stable=1; press_count=1; no further pulses while held.
3. Bouncy press: btn 1 for 2 cycles, 0 for 1, 1 for 2, 0 for 1, then steady 1 -> exactly one T pulse, 5 edges after the steady-1 segment starts; press_count=1.
4. Release with a 2-cycle high glitch during the low period -> stable stays 1 through the glitch, then falls after a clean low run; T never asserts on release.
5. 257 clean press/release cycles -> 257 single-cycle T pulses; press_count reads 1 after wrap. Downstream T flip-flop Q ends at 1 starting from 0.
6. Reset asserted during DB_HIGH (cnt=2) with btn held high -> T stays 0 and all outputs clear. After release, one pulse 5 edges later and press_count=1.
